lock_timer_arbiter: RTL and testbench

- Shares one prescaler and one down-counter among three requesters in the digital-lock controller.
- The requesters are the unlock-hold timer, the wrong-code lockout timer and the buzzer/LED timer.
- A requester asks for an interval of N slow ticks. The block arbitrates round-robin, runs the interval, then returns a done pulse.
- It replaces the per-function free-running slow-clock dividers with a single, clock-enable based, scheduled timer.

---
 rtl/lock_timer_arbiter.sv | 150 +++++++++++++++
 tb/tb_lock_timer_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lock_timer_arbiter.sv
// Shared tick timer for the lock controller: one prescaler and one interval
// down-counter, handed round-robin to three requesters (unlock hold,
// wrong-code lockout, buzzer/LED). Each grant runs N slow ticks and then
// returns a one-cycle done pulse to the owning channel.
module lock_timer_arbiter #(
  parameter int TICK_DIV = 40000000,
  parameter int CNT_W    = 26,
  parameter int DUR_W    = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [DUR_W-1:0] dur0,
  input  logic [DUR_W-1:0] dur1,
  input  logic [DUR_W-1:0] dur2,
  input  logic             abort,
  output logic [2:0]       gnt,
  output logic [2:0]       done,
  output logic             busy,
  output logic             tick,
  output logic [DUR_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   prescaler, pre_n;
  logic [1:0]         last_idx, last_n;
  logic [1:0]         idx, idx_n;
  logic [2:0]         gnt_n, done_n;
  logic               tick_n, busy_n;
  logic [DUR_W-1:0]   rem_n;

  logic               win_vld;
  logic [1:0]         win;
  logic [DUR_W-1:0]   win_dur;
  logic               last_tick;
  logic               cancel;

  // Round-robin pick: first pending channel after the last owner, with wrap.
  always_comb begin
    win_vld = |req;
    win     = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      int c;
      c = (int'(last_idx) + 1 + k) % 3;
      if (req[c]) win = 2'(c);
    end
    case (win)
      2'd0:    win_dur = dur0;
      2'd1:    win_dur = dur1;
      default: win_dur = dur2;
    endcase
  end

  assign last_tick = (prescaler == CNT_W'(TICK_DIV - 1));
  // Owner withdrawing its request is treated exactly like an abort.
  assign cancel    = abort || !req[idx];

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; cancel wins over a tick on the same edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (win_vld) next_state = (win_dur != '0) ? RUN : DONE;
      RUN: begin
        if (cancel)                                   next_state = DONE;
        else if (last_tick && remaining == DUR_W'(1)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/datapath next values; done and tick default low so they pulse.
  always_comb begin
    gnt_n  = gnt;
    done_n = '0;
    tick_n = 1'b0;
    rem_n  = remaining;
    pre_n  = prescaler;
    last_n = last_idx;
    idx_n  = idx;
    busy_n = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (win_vld) begin
          idx_n = win;
          rem_n = win_dur;
          pre_n = '0;
          if (win_dur != '0) begin
            gnt_n = 3'b001 << win;
          end else begin
            done_n[win] = 1'b1;
            last_n      = win;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          gnt_n  = '0;
          rem_n  = '0;
          pre_n  = '0;
          last_n = idx;
        end else if (last_tick) begin
          pre_n  = '0;
          tick_n = 1'b1;
          if (remaining != '0) rem_n = remaining - DUR_W'(1);
          if (remaining == DUR_W'(1)) begin
            gnt_n       = '0;
            done_n[idx] = 1'b1;
            last_n      = idx;
          end
        end else begin
          pre_n = prescaler + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Register every output; last_idx resets to 2 so channel 0 goes first.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
      prescaler <= '0;
      last_idx  <= 2'd2;
      idx       <= 2'd0;
    end else begin
      gnt       <= gnt_n;
      done      <= done_n;
      tick      <= tick_n;
      busy      <= busy_n;
      remaining <= rem_n;
      prescaler <= pre_n;
      last_idx  <= last_n;
      idx       <= idx_n;
    end
  end

endmodule

// File: tb/tb_lock_timer_arbiter.sv
// Bench for lock_timer_arbiter with a 4-cycle tick. Grant sequences are
// scoreboarded (expected owner and width queued at stimulus time, popped on
// each grant rise); the rest are directed cycle-exact checks.
module tb_lock_timer_arbiter;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;
  localparam int DUR_W    = 8;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [DUR_W-1:0] dur0, dur1, dur2;
  logic             abort;
  logic [2:0]       gnt, done;
  logic             busy, tick;
  logic [DUR_W-1:0] remaining;

  lock_timer_arbiter #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
    .clk_in(clk_in), .rst(rst), .req(req), .dur0(dur0), .dur1(dur1),
    .dur2(dur2), .abort(abort), .gnt(gnt), .done(done), .busy(busy),
    .tick(tick), .remaining(remaining)
  );

  always #5 clk_in = ~clk_in;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {logic [2:0] g; int w;} exp_t;
  exp_t sb[$];
  exp_t cur;
  bit   mon_en = 1'b0;
  logic [2:0] prev_g = '0;
  int   width = 0;

  // Scoreboard monitor: owner on grant rise, width and done on grant fall.
  always @(negedge clk_in) begin
    if (rst || !mon_en) begin
      prev_g = '0;
      width  = 0;
    end else begin
      if (gnt != '0 && prev_g == '0) begin
        width = 0;
        if (sb.size() == 0) chk("sb_unexpected_gnt", 32'(gnt), 32'd0);
        else begin
          cur = sb.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(cur.g));
        end
      end
      if (gnt != '0) width++;
      if (gnt == '0 && prev_g != '0) begin
        chk("sb_width", width, cur.w);
        chk("sb_done", 32'(done), 32'(prev_g));
      end
      prev_g = gnt;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; abort = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int ticks, rises, fall_c, c6;
    bit seen;
    dur0 = '0; dur1 = '0; dur2 = '0;
    do_reset();

    // Reset state.
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);

    // 1: single channel, dur=3 -> 12-cycle grant, 3 ticks every 4 cycles.
    mon_en = 1'b1;
    sb.push_back('{g: 3'b001, w: 12});
    dur0 = 8'd3; req = 3'b001;
    step();
    chk("t1_gnt", 32'(gnt), 32'd1);
    chk("t1_rem0", 32'(remaining), 32'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    ticks = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (tick) begin
        ticks++;
        chk("t1_tick_pos", c % 4, 0);
        chk("t1_rem", 32'(remaining), 32'(3 - ticks));
      end
    end
    chk("t1_ticks", ticks, 3);
    chk("t1_done", 32'(done), 32'b001);
    req = '0;
    step();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    step();
    chk("t1_drain", sb.size(), 0);

    // 2: all three, dur=1 -> 001,010,100,001 at 4 cycles each.
    mon_en = 1'b0; do_reset(); mon_en = 1'b1;
    dur0 = 8'd1; dur1 = 8'd1; dur2 = 8'd1;
    sb.push_back('{g: 3'b001, w: 4});
    sb.push_back('{g: 3'b010, w: 4});
    sb.push_back('{g: 3'b100, w: 4});
    sb.push_back('{g: 3'b001, w: 4});
    req = 3'b111;
    for (int c = 0; c < 23; c++) step();
    req = '0;
    step(); step(); step();
    chk("t2_drain", sb.size(), 0);

    // 3: req=011, dur=2 -> 001,010,001 with 2-cycle gaps.
    mon_en = 1'b0; do_reset(); mon_en = 1'b1;
    dur0 = 8'd2; dur1 = 8'd2;
    sb.push_back('{g: 3'b001, w: 8});
    sb.push_back('{g: 3'b010, w: 8});
    sb.push_back('{g: 3'b001, w: 8});
    req = 3'b011;
    rises = 0; fall_c = -1;
    begin
      logic [2:0] pg;
      pg = '0;
      for (int c = 0; c < 29; c++) begin
        step();
        if (gnt != '0 && pg == '0) begin
          rises++;
          if (fall_c >= 0) chk("t3_gap", c - fall_c, 2);
        end
        if (gnt == '0 && pg != '0) fall_c = c;
        pg = gnt;
      end
    end
    req = '0;
    step(); step();
    chk("t3_rises", rises, 3);
    chk("t3_drain", sb.size(), 0);
    mon_en = 1'b0;

    // 4: abort channel 1 at remaining=2; pending channel 2 gets in 2 edges later.
    do_reset();
    dur1 = 8'd3; dur2 = 8'd1;
    req = 3'b010;
    for (int c = 0; c < 5; c++) step();
    chk("t4_gnt", 32'(gnt), 32'b010);
    chk("t4_rem2", 32'(remaining), 32'd2);
    req = 3'b110; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_gnt", 32'(gnt), 32'd0);
    chk("t4_abort_rem", 32'(remaining), 32'd0);
    chk("t4_abort_done", 32'(done), 32'd0);
    step();
    chk("t4_done_quiet", 32'(done), 32'd0);
    chk("t4_gap_gnt", 32'(gnt), 32'd0);
    step();
    chk("t4_regrant", 32'(gnt), 32'b100);
    chk("t4_regrant_rem", 32'(remaining), 32'd1);
    for (int c = 0; c < 4; c++) step();
    chk("t4_done2", 32'(done), 32'b100);
    req = '0;
    step(); step();

    // 5: zero-length interval -> no grant, immediate done.
    do_reset();
    dur2 = 8'd0; req = 3'b100;
    step();
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_done", 32'(done), 32'b100);
    chk("t5_busy", 32'(busy), 32'd1);
    req = '0;
    step();
    chk("t5_done_off", 32'(done), 32'd0);
    chk("t5_gnt_off", 32'(gnt), 32'd0);
    step();
    chk("t5_busy_off", 32'(busy), 32'd0);

    // 6: async reset mid-interval, then full-length first tick after regrant.
    do_reset();
    dur0 = 8'd3; req = 3'b001;
    step(); step(); step();
    chk("t6_gnt_pre", 32'(gnt), 32'b001);
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rem", 32'(remaining), 32'd0);
    chk("t6_rst_tick_done", 32'({tick, done}), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_regrant", 32'(gnt), 32'b001);
    seen = 1'b0; c6 = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      step();
      if (tick) begin seen = 1'b1; c6 = c; end
    end
    chk("t6_first_tick", c6, 4);
    req = '0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
